// File: rtl/vrf_pkg.sv
// Shared constants and types for the vector register file read streamer.
package vrf_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_REG    = 6;
    localparam int NUM_ELE    = 32;

    // Element count / element counter; one bit wider than an element index
    // so that a full register (NUM_ELE) is representable without wrapping.
    typedef logic [ADDR_WIDTH:0] count_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] NUM_REG_A = ADDR_WIDTH'(NUM_REG);
    localparam count_t                NUM_ELE_C = count_t'(NUM_ELE);

    // Oversized requests are trimmed to one full register.
    function automatic count_t clamp_vl(input count_t vl);
        return (vl > NUM_ELE_C) ? NUM_ELE_C : vl;
    endfunction

endpackage

// File: rtl/vrf_stream_outreg.sv
// Single-entry valid/ready output register carrying element data, index and last flag.
module vrf_stream_outreg
    import vrf_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] in_idx,
    input  logic                  in_last,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  out_last
);

    // Load a new element, or retire the held one on a handshake; otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_idx   <= in_idx;
            out_last  <= in_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vrf_elem_streamer.sv
// Walks elements 0..vl-1 of one vector register through a combinational
// register-file read port and emits them on a valid/ready stream.
//
//   state | meaning
//   IDLE  | waiting for a command; cmd_ready high, read address parked at 0
//   READ  | reading element idx and loading the output register when it frees
//   DRAIN | last element loaded; waiting for its handshake before done
module vrf_elem_streamer
    import vrf_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_vreg,
    input  logic [ADDR_WIDTH:0]   cmd_vl,
    output logic [ADDR_WIDTH-1:0] rAddr1,
    output logic [ADDR_WIDTH-1:0] rAddr2,
    input  logic [DATA_WIDTH-1:0] rData,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  out_last,
    output logic                  done,
    output logic                  err
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] vreg_q;
    count_t                vl_q;
    count_t                idx_q;
    logic                  done_q;
    logic                  err_q;

    logic                  cmd_accept;
    logic                  cmd_bad;
    count_t                cmd_vl_c;
    logic                  load;
    logic                  is_last;
    logic                  out_hs;

    assign cmd_ready  = (state_q == IDLE);
    assign cmd_accept = cmd_valid && cmd_ready;
    assign cmd_bad    = (cmd_vreg >= NUM_REG_A);
    assign cmd_vl_c   = clamp_vl(cmd_vl);
    assign load       = (state_q == READ) && (!out_valid || out_ready);
    assign is_last    = (idx_q == (vl_q - count_t'(1)));
    assign out_hs     = out_valid && out_ready;

    assign rAddr1 = (state_q != IDLE) ? vreg_q : '0;
    assign rAddr2 = (state_q != IDLE) ? idx_q[ADDR_WIDTH-1:0] : '0;
    assign done   = done_q;
    assign err    = err_q;

    // Next-state decode for the command/element sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_accept && !cmd_bad && (cmd_vl_c != '0)) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (load && is_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, command latches, element counter and the done/err pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            vreg_q  <= '0;
            vl_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (cmd_accept && !cmd_bad && (cmd_vl_c == '0))
                       || ((state_q == DRAIN) && out_hs);
            err_q   <= cmd_accept && cmd_bad;
            if (cmd_accept) begin
                vreg_q <= cmd_vreg;
                vl_q   <= cmd_vl_c;
                idx_q  <= '0;
            end else if (load) begin
                idx_q  <= idx_q + count_t'(1);
            end
        end
    end

    vrf_stream_outreg u_outreg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .in_data   (rData),
        .in_idx    (idx_q[ADDR_WIDTH-1:0]),
        .in_last   (is_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_vrf_elem_streamer.sv
// Scoreboard bench for vrf_elem_streamer with a behavioural register file.
module tb_vrf_elem_streamer;
    import vrf_pkg::*;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] idx;
        logic                  last;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_vreg = '0;
    logic [ADDR_WIDTH:0]   cmd_vl = '0;
    logic [ADDR_WIDTH-1:0] rAddr1;
    logic [ADDR_WIDTH-1:0] rAddr2;
    logic [DATA_WIDTH-1:0] rData;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_idx;
    logic                  out_last;
    logic                  done;
    logic                  err;

    logic [DATA_WIDTH-1:0] rf [NUM_REG][NUM_ELE];
    exp_t sb[$];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int done_cnt, err_cnt, hs_cnt, valid_cnt;
    int first_hs, last_hs, done_cyc, acc_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        rData = '0;
        if (int'(rAddr1) < NUM_REG) rData = rf[rAddr1][rAddr2];
    end

    vrf_elem_streamer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_vreg  (cmd_vreg),
        .cmd_vl    (cmd_vl),
        .rAddr1    (rAddr1),
        .rAddr2    (rAddr2),
        .rData     (rData),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done),
        .err       (err)
    );

    // Stream monitor: pops the scoreboard on every handshake and checks stall stability.
    task automatic monitor();
        exp_t e;
        exp_t held;
        logic stall;
        stall = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                tests_run++;
                if (out_valid !== 1'b1 || {out_data, out_idx, out_last} !== held) begin
                    tests_failed++;
                    $display("FAIL stall_hold: got v=%b d=%h i=%0d l=%b, want v=1 d=%h i=%0d l=%b",
                             out_valid, out_data, out_idx, out_last, held.data, held.idx, held.last);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err === 1'b1) err_cnt++;
            if (out_valid === 1'b1) valid_cnt++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (hs_cnt == 0) first_hs = cyc;
                last_hs = cyc;
                hs_cnt++;
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL stream_extra: got idx %0d data %h, want no element", out_idx, out_data);
                end else begin
                    e = sb.pop_front();
                    if ({out_data, out_idx, out_last} !== e) begin
                        tests_failed++;
                        $display("FAIL stream_elem: got d=%h i=%0d l=%b, want d=%h i=%0d l=%b",
                                 out_data, out_idx, out_last, e.data, e.idx, e.last);
                    end
                end
            end
            stall = out_valid && !out_ready;
            held = {out_data, out_idx, out_last};
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        done_cnt = 0; err_cnt = 0; hs_cnt = 0; valid_cnt = 0;
        first_hs = -1; last_hs = -1; done_cyc = -1;
    endtask

    task automatic send_cmd(input int vreg, input int vl);
        step();
        cmd_valid = 1'b1;
        cmd_vreg  = ADDR_WIDTH'(vreg);
        cmd_vl    = (ADDR_WIDTH+1)'(vl);
        step();
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic push_exp(input int vreg, input int vl);
        exp_t e;
        for (int i = 0; i < vl; i++) begin
            e.data = rf[vreg][i];
            e.idx  = ADDR_WIDTH'(i);
            e.last = (i == vl - 1);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_cnt > 0) break;
        end
        step();
        step();
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if (cmd_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got rdy=%b v=%b done=%b err=%b, want 1 0 0 0",
                     cmd_ready, out_valid, done, err);
        end
        tests_run++;
        if (rAddr1 !== '0 || rAddr2 !== '0 || out_data !== '0 || out_idx !== '0 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_data: got a1=%0d a2=%0d d=%h i=%0d l=%b, want all 0",
                     rAddr1, rAddr2, out_data, out_idx, out_last);
        end
        step();
        reset_n = 1'b1;
        step();
        tests_run++;
        if (cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got rdy=%b v=%b, want 1 0", cmd_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        clear_counts();
        push_exp(2, 4);
        out_ready = 1'b1;
        send_cmd(2, 4);
        wait_done(20);
        tests_run++;
        if (sb.size() != 0 || hs_cnt != 4) begin
            tests_failed++;
            $display("FAIL basic_count: got hs=%0d left=%0d, want hs=4 left=0", hs_cnt, sb.size());
        end
        tests_run++;
        if (first_hs != acc_cyc + 1 || last_hs - first_hs != 3) begin
            tests_failed++;
            $display("FAIL basic_timing: got first=%0d last=%0d, want first=%0d last=%0d",
                     first_hs, last_hs, acc_cyc + 1, acc_cyc + 4);
        end
        tests_run++;
        if (done_cnt != 1 || done_cyc != acc_cyc + 5 || err_cnt != 0) begin
            tests_failed++;
            $display("FAIL basic_done: got n=%0d cyc=%0d err=%0d, want n=1 cyc=%0d err=0",
                     done_cnt, done_cyc, err_cnt, acc_cyc + 5);
        end
    endtask

    task automatic test_stall();
        clear_counts();
        push_exp(2, 4);
        out_ready = 1'b1;
        send_cmd(2, 4);
        for (int k = 0; k < 60; k++) begin
            out_ready = (k % 3 == 0);
            step();
            if (done_cnt > 0) break;
        end
        out_ready = 1'b1;
        step();
        step();
        tests_run++;
        if (sb.size() != 0 || hs_cnt != 4 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL stall_stream: got hs=%0d left=%0d done=%0d, want 4 0 1",
                     hs_cnt, sb.size(), done_cnt);
        end
    endtask

    task automatic test_zero_and_err();
        clear_counts();
        send_cmd(2, 0);
        step(); step(); step();
        tests_run++;
        if (done_cnt != 1 || valid_cnt != 0 || err_cnt != 0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_vl: got done=%0d valid=%0d err=%0d rdy=%b, want 1 0 0 1",
                     done_cnt, valid_cnt, err_cnt, cmd_ready);
        end
        clear_counts();
        send_cmd(7, 5);
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bad_vreg_ready: got rdy=%b, want 1", cmd_ready);
        end
        step(); step(); step();
        tests_run++;
        if (err_cnt != 1 || valid_cnt != 0 || done_cnt != 0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bad_vreg: got err=%0d valid=%0d done=%0d rdy=%b, want 1 0 0 1",
                     err_cnt, valid_cnt, done_cnt, cmd_ready);
        end
    endtask

    task automatic test_clamp();
        clear_counts();
        push_exp(5, 32);
        out_ready = 1'b1;
        send_cmd(5, 40);
        wait_done(60);
        tests_run++;
        if (sb.size() != 0 || hs_cnt != 32) begin
            tests_failed++;
            $display("FAIL clamp_count: got hs=%0d left=%0d, want hs=32 left=0", hs_cnt, sb.size());
        end
        tests_run++;
        if (done_cnt != 1 || done_cyc != acc_cyc + 33) begin
            tests_failed++;
            $display("FAIL clamp_done: got n=%0d cyc=%0d, want n=1 cyc=%0d",
                     done_cnt, done_cyc, acc_cyc + 33);
        end
    endtask

    task automatic test_reset_mid();
        int dc;
        clear_counts();
        push_exp(3, 8);
        out_ready = 1'b1;
        send_cmd(3, 8);
        step(); step(); step();
        tests_run++;
        if (out_valid !== 1'b1 || out_idx !== 5'd2) begin
            tests_failed++;
            $display("FAIL mid_pre: got v=%b i=%0d, want v=1 i=2", out_valid, out_idx);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset: got v=%b rdy=%b, want v=0 rdy=1", out_valid, cmd_ready);
        end
        dc = done_cnt;
        sb.delete();
        step();
        step();
        reset_n = 1'b1;
        step(); step(); step();
        tests_run++;
        if (done_cnt != dc || valid_cnt > 3) begin
            tests_failed++;
            $display("FAIL mid_abort: got done=%0d valid=%0d, want done=%0d valid<=3",
                     done_cnt, valid_cnt, dc);
        end
        clear_counts();
        push_exp(3, 3);
        send_cmd(3, 3);
        wait_done(20);
        tests_run++;
        if (sb.size() != 0 || hs_cnt != 3 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL mid_restart: got hs=%0d left=%0d done=%0d, want 3 0 1",
                     hs_cnt, sb.size(), done_cnt);
        end
    endtask

    task automatic test_write_stall();
        exp_t e;
        clear_counts();
        push_exp(1, 6);
        e = sb[3];
        e.data = 32'hDEAD;
        sb[3] = e;
        out_ready = 1'b1;
        send_cmd(1, 6);
        step();
        step();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_idx !== 5'd1) begin
            tests_failed++;
            $display("FAIL wr_stall_pos: got v=%b i=%0d, want v=1 i=1", out_valid, out_idx);
        end
        step(); step();
        rf[1][3] = 32'hDEAD;
        step();
        out_ready = 1'b1;
        wait_done(30);
        tests_run++;
        if (sb.size() != 0 || hs_cnt != 6 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL wr_stream: got hs=%0d left=%0d done=%0d, want 6 0 1",
                     hs_cnt, sb.size(), done_cnt);
        end
    endtask

    initial begin
        for (int r = 0; r < NUM_REG; r++)
            for (int i = 0; i < NUM_ELE; i++)
                rf[r][i] = 32'(r * 32'h100 + i);
        clear_counts();
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_stall();
        test_zero_and_err();
        test_clamp();
        test_reset_mid();
        test_write_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
